// File: rtl/aes_pkg.sv
// Shared AES types, constants and helpers for the key schedule and cipher core.
package aes_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      EXPAND,
      FINISH
   } ks_state_t;

   localparam logic [7:0] RCON [1:10] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
      8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
      8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
      8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
      8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
      8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
      8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
      8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
      8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
      8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
      8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
      8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
      8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
      8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
      8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
      8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
      8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Cyclic left rotate by one byte: {a0,a1,a2,a3} -> {a1,a2,a3,a0}.
   function automatic word_t rot_word(input word_t i_w);
      return {i_w[23:0], i_w[31:24]};
   endfunction

   // Round constant for rounds 1..10; zero for any other counter value.
   function automatic logic [7:0] rcon_lookup(input logic [3:0] i_round);
      logic [7:0] v_rc;
      v_rc = 8'h00;
      for (int i = 1; i <= 10; i++) begin
         if (i_round == 4'(i)) v_rc = RCON[i];
      end
      return v_rc;
   endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: four parallel S-box lookups on a 32-bit word.
module aes_subword
   import aes_pkg::*;
(
   input  word_t i_word,
   output word_t o_word
);

   assign o_word = {SBOX[i_word[31:24]], SBOX[i_word[23:16]],
                    SBOX[i_word[15:8]],  SBOX[i_word[7:0]]};

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion: one round key per clock, full schedule held
// on KEYSCHEDULE and qualified by DONE.
module aes_key_schedule
   import aes_pkg::*;
#(
   parameter int unsigned ROUNDS = 10
) (
   input  logic            CLK,
   input  logic            RESET_N,
   input  logic            START,
   input  logic [127:0]    KEY,
   output logic            BUSY,
   output logic            DONE,
   output logic [1407:0]   KEYSCHEDULE
);

   localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);

   if (ROUNDS != 10) begin : g_bad_rounds
      $error("aes_key_schedule: only ROUNDS = 10 (AES-128) is supported");
   end

   ks_state_t       r_state, w_state_d;
   logic [3:0]      r_round, w_round_d;
   logic [127:0]    r_work,  w_work_d;
   logic [1407:0]   r_ks,    w_ks_d;
   logic            r_busy,  w_busy_d;
   logic            r_done,  w_done_d;

   word_t           w_rot, w_sub, w_temp;
   word_t           w_n0, w_n1, w_n2, w_n3;
   logic [127:0]    w_new;

   // Shared single-word S-box path for the round function.
   aes_subword u_subword (
      .i_word (w_rot),
      .o_word (w_sub)
   );

   // Next round key from the working register (w0 at [127:96], w3 at [31:0]).
   always_comb begin
      w_rot  = rot_word(r_work[31:0]);
      w_temp = w_sub ^ {rcon_lookup(r_round), 24'h0};
      w_n0   = r_work[127:96] ^ w_temp;
      w_n1   = r_work[95:64]  ^ w_n0;
      w_n2   = r_work[63:32]  ^ w_n1;
      w_n3   = r_work[31:0]   ^ w_n2;
      w_new  = {w_n0, w_n1, w_n2, w_n3};
   end

   // Next-state and registered-output logic.
   always_comb begin
      w_state_d = r_state;
      w_round_d = r_round;
      w_work_d  = r_work;
      w_ks_d    = r_ks;
      w_busy_d  = r_busy;
      w_done_d  = r_done;
      case (r_state)
         IDLE: begin
            w_busy_d = 1'b0;
            w_done_d = 1'b0;
            if (START) begin
               w_state_d           = LOAD;
               w_work_d            = KEY;
               w_ks_d[1407 -: 128] = KEY;
               w_round_d           = 4'd1;
               w_busy_d            = 1'b1;
            end
         end
         // LOAD already computes round 1 so round r lands on edge k+r.
         LOAD, EXPAND: begin
            if (r_round == 4'd0 || r_round > LAST_ROUND) begin
               w_state_d = IDLE;
               w_round_d = 4'd0;
               w_busy_d  = 1'b0;
               w_done_d  = 1'b0;
            end else begin
               for (int s = 1; s <= 10; s++) begin
                  if (r_round == 4'(s)) w_ks_d[1407 - 128*s -: 128] = w_new;
               end
               w_work_d = w_new;
               if (r_round == LAST_ROUND) begin
                  w_state_d = FINISH;
                  w_busy_d  = 1'b0;
                  w_done_d  = 1'b1;
               end else begin
                  w_state_d = EXPAND;
                  w_round_d = r_round + 4'd1;
                  w_busy_d  = 1'b1;
               end
            end
         end
         FINISH: begin
            w_busy_d = 1'b0;
            w_done_d = 1'b1;
            if (!START) begin
               w_state_d = IDLE;
               w_round_d = 4'd0;
               w_done_d  = 1'b0;
            end
         end
         default: begin
            w_state_d = IDLE;
            w_round_d = 4'd0;
            w_busy_d  = 1'b0;
            w_done_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any expansion in progress.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state <= IDLE;
         r_round <= 4'd0;
         r_work  <= '0;
         r_ks    <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_round <= w_round_d;
         r_work  <= w_work_d;
         r_ks    <= w_ks_d;
         r_busy  <= w_busy_d;
         r_done  <= w_done_d;
      end
   end

   assign BUSY        = r_busy;
   assign DONE        = r_done;
   assign KEYSCHEDULE = r_ks;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Scoreboard bench for aes_key_schedule: expected schedules are queued at
// START and compared slot by slot whenever DONE rises.
module tb_aes_key_schedule;

   logic          CLK = 1'b0;
   logic          RESET_N;
   logic          START;
   logic [127:0]  KEY;
   logic          BUSY;
   logic          DONE;
   logic [1407:0] KEYSCHEDULE;

   localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int k_edge   = 0;
   logic [7:0]    sb_ref [256];
   logic [1407:0] exp_q [$];
   logic          done_prev = 1'b0;

   aes_key_schedule #(.ROUNDS(10)) dut (
      .CLK         (CLK),
      .RESET_N     (RESET_N),
      .START       (START),
      .KEY         (KEY),
      .BUSY        (BUSY),
      .DONE        (DONE),
      .KEYSCHEDULE (KEYSCHEDULE)
   );

   always #10 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   // S-box from its definition: multiplicative inverse then affine map.
   task automatic build_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv;
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         sb_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4)
                     ^ 8'h63;
      end
   endtask

   // Textbook 44-word expansion; word i lands at [1407-32*i -: 32].
   function automatic logic [1407:0] expand_ref(input logic [127:0] key);
      logic [31:0]   w [44];
      logic [31:0]   t;
      logic [7:0]    rc;
      logic [1407:0] ks;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sb_ref[t[31:24]], sb_ref[t[23:16]], sb_ref[t[15:8]], sb_ref[t[7:0]]};
            t[31:24] = t[31:24] ^ rc;
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int i = 0; i < 44; i++) ks[1407 - 32*i -: 32] = w[i];
      return ks;
   endfunction

   // Monitor: on each DONE rising edge compare all eleven slots with the queue head.
   always @(negedge CLK) begin
      if (DONE && !done_prev) begin
         if (exp_q.size() == 0) begin
            check("done_unexpected", 128'(DONE), 128'd0);
         end else begin
            logic [1407:0] e;
            e = exp_q.pop_front();
            for (int r = 0; r <= 10; r++)
               check($sformatf("slot%0d", r), KEYSCHEDULE[1407 - 128*r -: 128],
                     e[1407 - 128*r -: 128]);
         end
      end
      done_prev <= DONE;
   end

   // Issue a START from IDLE; returns at the negedge after the sampling edge.
   task automatic issue(input logic [127:0] key, input bit push);
      @(negedge CLK);
      KEY   = key;
      START = 1'b1;
      if (push) exp_q.push_back(expand_ref(key));
      @(posedge CLK);
      @(negedge CLK);
      k_edge = cyc;
      check("busy_after_start", 128'(BUSY), 128'd1);
   endtask

   // Bounded wait for DONE; also checks START-to-DONE latency.
   task automatic wait_done(input string name);
      while (!DONE && (cyc - k_edge) < 30) @(negedge CLK);
      check({name, "_latency"}, 128'(cyc - k_edge), 128'd10);
   endtask

   initial begin
      logic [1407:0] saved;
      bit            ok;
      RESET_N = 1'b0;
      START   = 1'b0;
      KEY     = '0;
      build_sbox();
      #25;
      check("reset_busy", 128'(BUSY), 128'd0);
      check("reset_done", 128'(DONE), 128'd0);
      check("reset_ks_zero", 128'(|KEYSCHEDULE), 128'd0);
      @(negedge CLK);
      RESET_N = 1'b1;

      // FIPS-197 C.1 key with published round values.
      issue(KEY_C1, 1'b1);
      wait_done("c1");
      check("c1_round1", KEYSCHEDULE[1279 -: 128], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
      check("c1_round10", KEYSCHEDULE[127:0], 128'h13111d7fe3944a17f307a78b4d2b30c5);

      // Handshake: DONE held while START stays high, schedule stable.
      saved = KEYSCHEDULE;
      ok    = 1'b1;
      repeat (20) begin
         @(negedge CLK);
         if (!DONE || BUSY || KEYSCHEDULE !== saved) ok = 1'b0;
      end
      check("hold_stable", 128'(ok), 128'd1);
      START = 1'b0;
      @(negedge CLK);
      check("drop_done", 128'(DONE), 128'd0);
      check("drop_busy", 128'(BUSY), 128'd0);
      issue(KEY_C1, 1'b1);
      wait_done("c1_again");

      // Mid-run KEY change and START pulse must not disturb the expansion.
      START = 1'b0;
      issue(KEY_C1, 1'b1);
      START = 1'b0;
      ok    = 1'b1;
      while (cyc - k_edge < 9) begin
         @(negedge CLK);
         if (!BUSY) ok = 1'b0;
         if (cyc - k_edge == 3) begin
            KEY   = '1;
            START = 1'b1;
         end else begin
            START = 1'b0;
         end
      end
      check("midrun_busy", 128'(ok), 128'd1);
      wait_done("midrun");

      // Asynchronous reset between edges around round 6.
      issue(KEY_A1, 1'b0);
      START = 1'b0;
      while (cyc - k_edge < 5) @(negedge CLK);
      #3 RESET_N = 1'b0;
      #1;
      check("abort_busy", 128'(BUSY), 128'd0);
      check("abort_done", 128'(DONE), 128'd0);
      check("abort_ks_zero", 128'(|KEYSCHEDULE), 128'd0);
      @(negedge CLK);
      RESET_N = 1'b1;
      issue(KEY_A1, 1'b1);
      wait_done("a1");
      check("a1_round1", KEYSCHEDULE[1279 -: 128], 128'ha0fafe1788542cb123a339392a6c7605);
      check("a1_round10", KEYSCHEDULE[127:0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      // Back-to-back C.1 then A.1 with a single low cycle of START.
      START = 1'b0;
      issue(KEY_C1, 1'b1);
      wait_done("b2b_c1");
      START = 1'b0;
      issue(KEY_A1, 1'b1);
      wait_done("b2b_a1");

      // Random keys.
      for (int n = 0; n < 4; n++) begin
         START = 1'b0;
         issue({$urandom, $urandom, $urandom, $urandom}, 1'b1);
         wait_done($sformatf("rand%0d", n));
      end

      START = 1'b0;
      repeat (3) @(negedge CLK);
      check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
